// File: rtl/run_sequencer.sv
// run_sequencer: host-side batch sequencer in front of the processor top level.
// Each run does the following in order:
//   1. Streams LOAD_WORDS operands into data memory.
//   2. Pulses req to start the processor.
//   3. Counts RUN cycles until ack.
//   4. Streams RESULT_WORDS results back out.
// Optional build macro: RUN_TIMEOUT_EN. When it is defined, a run that has
// seen no ack after TIMEOUT_CYCLES RUN cycles is abandoned and goes straight
// to DONE with timed_out set.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for go; last cycle_count / timed_out held
// LOAD   | accepting operand words, one memory write per transfer
// START  | single-cycle req pulse to the processor
// RUN    | processor owns memory; count cycles until ack (or timeout)
// UNLOAD | presenting result words read combinationally from memory
// DONE   | single-cycle done pulse, then back to IDLE
`timescale 1ns/1ps

module run_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int LOAD_WORDS     = 4,
  parameter int LOAD_BASE      = 0,
  parameter int RESULT_WORDS   = 2,
  parameter int RESULT_BASE    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [15:0]       cycle_count,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              host_mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              req,
  input  logic              ack
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Index counters only need to span 0 .. WORDS-1.
  localparam int LIDX_W = (LOAD_WORDS   < 2) ? 1 : $clog2(LOAD_WORDS);
  localparam int RIDX_W = (RESULT_WORDS < 2) ? 1 : $clog2(RESULT_WORDS);

  localparam logic [LIDX_W-1:0] LOAD_LAST = LIDX_W'(LOAD_WORDS - 1);
  localparam logic [RIDX_W-1:0] RES_LAST  = RIDX_W'(RESULT_WORDS - 1);

  localparam logic [ADDR_W-1:0] LOAD_BASE_A   = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] RESULT_BASE_A = ADDR_W'(RESULT_BASE);
  localparam logic [31:0]       TIMEOUT_LIM   = 32'(TIMEOUT_CYCLES);

  localparam bit NO_LOAD   = (LOAD_WORDS == 0);
  localparam bit NO_RESULT = (RESULT_WORDS == 0);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [LIDX_W-1:0] load_idx;
  logic [RIDX_W-1:0] res_idx;
  logic [15:0]       count_q;
  logic [15:0]       count_next;
  logic              timed_out_q;
  logic              load_fire;
  logic              res_fire;
  logic              load_last;
  logic              res_last;
  logic              limit_reached;
  logic              timeout_hit;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] res_addr;

  // Handshake qualifiers, saturating RUN counter and the timeout decision.
  always_comb begin
    load_fire     = (state == S_LOAD) && load_valid;
    res_fire      = (state == S_UNLOAD) && res_ready;
    load_last     = (load_idx == LOAD_LAST);
    res_last      = (res_idx == RES_LAST);
    count_next    = (count_q == 16'hFFFF) ? 16'hFFFF : count_q + 16'd1;
    // The limit compares against the count that this RUN cycle will produce.
    // That way the run ends exactly after TIMEOUT_CYCLES counted cycles.
    limit_reached = ({16'd0, count_next} >= TIMEOUT_LIM);
`ifdef RUN_TIMEOUT_EN
    timeout_hit   = limit_reached;
`else
    // Without the timeout build the limit is computed but never acted on.
    timeout_hit   = limit_reached & 1'b0;
`endif
    load_addr     = LOAD_BASE_A + ADDR_W'(load_idx);
    res_addr      = RESULT_BASE_A + ADDR_W'(res_idx);
  end

  // Next-state decode; ack is only looked at in RUN.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (go) state_next = NO_LOAD ? S_START : S_LOAD;
      end
      S_LOAD: begin
        if (load_fire && load_last) state_next = S_START;
      end
      S_START: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (ack)              state_next = NO_RESULT ? S_DONE : S_UNLOAD;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_UNLOAD: begin
        if (res_fire && res_last) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, indices, cycle counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      load_idx    <= '0;
      res_idx     <= '0;
      count_q     <= 16'd0;
      timed_out_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (go) begin
            load_idx    <= '0;
            res_idx     <= '0;
            count_q     <= 16'd0;
            timed_out_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_fire) load_idx <= load_idx + 1'b1;
        end
        S_RUN: begin
          count_q <= count_next;
          if (!ack && timeout_hit) timed_out_q <= 1'b1;
        end
        S_UNLOAD: begin
          if (res_fire) res_idx <= res_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. Everything is idle-low outside its owning state.
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    req          = (state == S_START);
    load_ready   = (state == S_LOAD);
    res_valid    = (state == S_UNLOAD);
    host_mem_sel = (state == S_LOAD) || (state == S_UNLOAD);
    mem_we       = load_fire;
    mem_wdata    = load_fire ? load_data : '0;
    res_data     = (state == S_UNLOAD) ? mem_rdata : '0;
    timed_out    = timed_out_q;
    cycle_count  = count_q;
    case (state)
      S_LOAD:   mem_addr = load_addr;
      S_UNLOAD: mem_addr = res_addr;
      default:  mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer. It uses three instances:
//   a: default geometry with TIMEOUT_CYCLES=8
//   z: zero load and result words
//   w: address wrap from LOAD_BASE=254
// Stimulus pushes expected writes, results and done records into queues.
// A negedge monitor pops and compares them whenever a DUT presents them.
`timescale 1ns/1ps

module tb_run_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- instance a ----------------
  logic go_a, busy_a, done_a, timed_out_a, load_valid_a, load_ready_a;
  logic res_valid_a, res_ready_a, host_mem_sel_a, mem_we_a, req_a, ack_a;
  logic [15:0] cycle_count_a;
  logic [7:0] load_data_a, res_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [7:0] mem_a [256];

  run_sequencer #(.TIMEOUT_CYCLES(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .go(go_a), .busy(busy_a), .done(done_a),
    .timed_out(timed_out_a), .cycle_count(cycle_count_a),
    .load_valid(load_valid_a), .load_ready(load_ready_a), .load_data(load_data_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a), .res_data(res_data_a),
    .host_mem_sel(host_mem_sel_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .req(req_a), .ack(ack_a));

  always @(posedge clock) begin
    if (!reset_n) begin
      mem_a[64] <= 8'hA5;
      mem_a[65] <= 8'h5A;
    end else if (mem_we_a) begin
      mem_a[mem_addr_a] <= mem_wdata_a;
    end
  end
  assign mem_rdata_a = mem_a[mem_addr_a];

  // ---------------- instance z ----------------
  logic go_z, busy_z, done_z, timed_out_z, load_valid_z, load_ready_z;
  logic res_valid_z, res_ready_z, host_mem_sel_z, mem_we_z, req_z, ack_z;
  logic [15:0] cycle_count_z;
  logic [7:0] load_data_z, res_data_z, mem_addr_z, mem_wdata_z, mem_rdata_z;

  run_sequencer #(.LOAD_WORDS(0), .RESULT_WORDS(0)) dut_z (
    .clock(clock), .reset_n(reset_n), .go(go_z), .busy(busy_z), .done(done_z),
    .timed_out(timed_out_z), .cycle_count(cycle_count_z),
    .load_valid(load_valid_z), .load_ready(load_ready_z), .load_data(load_data_z),
    .res_valid(res_valid_z), .res_ready(res_ready_z), .res_data(res_data_z),
    .host_mem_sel(host_mem_sel_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z),
    .mem_wdata(mem_wdata_z), .mem_rdata(mem_rdata_z), .req(req_z), .ack(ack_z));

  assign mem_rdata_z = mem_addr_z ^ 8'h3C;

  // ---------------- instance w ----------------
  logic go_w, busy_w, done_w, timed_out_w, load_valid_w, load_ready_w;
  logic res_valid_w, res_ready_w, host_mem_sel_w, mem_we_w, req_w, ack_w;
  logic [15:0] cycle_count_w;
  logic [7:0] load_data_w, res_data_w, mem_addr_w, mem_wdata_w, mem_rdata_w;
  logic [7:0] mem_w [256];

  run_sequencer #(.LOAD_BASE(254), .LOAD_WORDS(4), .RESULT_WORDS(1),
                  .RESULT_BASE(255)) dut_w (
    .clock(clock), .reset_n(reset_n), .go(go_w), .busy(busy_w), .done(done_w),
    .timed_out(timed_out_w), .cycle_count(cycle_count_w),
    .load_valid(load_valid_w), .load_ready(load_ready_w), .load_data(load_data_w),
    .res_valid(res_valid_w), .res_ready(res_ready_w), .res_data(res_data_w),
    .host_mem_sel(host_mem_sel_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w),
    .mem_wdata(mem_wdata_w), .mem_rdata(mem_rdata_w), .req(req_w), .ack(ack_w));

  always @(posedge clock) if (mem_we_w) mem_w[mem_addr_w] <= mem_wdata_w;
  assign mem_rdata_w = mem_w[mem_addr_w];

  // ---------------- scoreboard queues ----------------
  logic [15:0] exp_wr_a[$], exp_wr_w[$];   // {addr, data}
  logic [7:0]  exp_res_a[$], exp_res_w[$];
  logic [16:0] exp_done_a[$], exp_done_w[$]; // {timed_out, cycle_count}
  int req_cnt_a = 0, req_cnt_z = 0, req_cnt_w = 0;
  int req_base_a = 0;

  // Monitor: pop and compare whenever a DUT presents an observable event.
  always @(negedge clock) begin
    logic [15:0] mw;
    logic [7:0]  mr;
    logic [16:0] md;
    if (reset_n) begin
      if (req_a) req_cnt_a++;
      if (req_z) req_cnt_z++;
      if (req_w) req_cnt_w++;
      if (mem_we_a) begin
        if (exp_wr_a.size() == 0) chk("a_wr_unexpected", int'(mem_addr_a), -1);
        else begin
          mw = exp_wr_a.pop_front();
          chk("a_wr_addr", int'(mem_addr_a), int'(mw[15:8]));
          chk("a_wr_data", int'(mem_wdata_a), int'(mw[7:0]));
        end
      end
      if (res_valid_a && res_ready_a) begin
        if (exp_res_a.size() == 0) chk("a_res_unexpected", int'(res_data_a), -1);
        else begin
          mr = exp_res_a.pop_front();
          chk("a_res_data", int'(res_data_a), int'(mr));
        end
      end
      if (done_a) begin
        if (exp_done_a.size() == 0) chk("a_done_unexpected", 1, 0);
        else begin
          md = exp_done_a.pop_front();
          chk("a_done_cycle_count", int'(cycle_count_a), int'(md[15:0]));
          chk("a_done_timed_out", int'(timed_out_a), int'(md[16]));
        end
      end
      if (mem_we_w) begin
        if (exp_wr_w.size() == 0) chk("w_wr_unexpected", int'(mem_addr_w), -1);
        else begin
          mw = exp_wr_w.pop_front();
          chk("w_wr_addr", int'(mem_addr_w), int'(mw[15:8]));
          chk("w_wr_data", int'(mem_wdata_w), int'(mw[7:0]));
        end
      end
      if (res_valid_w && res_ready_w) begin
        if (exp_res_w.size() == 0) chk("w_res_unexpected", int'(res_data_w), -1);
        else begin
          mr = exp_res_w.pop_front();
          chk("w_res_data", int'(res_data_w), int'(mr));
        end
      end
      if (done_w) begin
        if (exp_done_w.size() == 0) chk("w_done_unexpected", 1, 0);
        else begin
          md = exp_done_w.pop_front();
          chk("w_done_cycle_count", int'(cycle_count_w), int'(md[15:0]));
          chk("w_done_timed_out", int'(timed_out_w), int'(md[16]));
        end
      end
      if (mem_we_z || res_valid_z)
        chk("z_stream_unexpected", int'({mem_we_z, res_valid_z, mem_wdata_z, res_data_z}), 0);
    end
  end

  // ---------------- stimulus helpers (instance a) ----------------
  task automatic go_pulse_a;
    req_base_a = req_cnt_a;
    go_a = 1'b1;
    @(posedge clock); #1 go_a = 1'b0;
  endtask

  // Four words, MSB byte first, written at addresses 0..3.
  task automatic load_a(input logic [31:0] words, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      w = words[31-8*i -: 8];
      exp_wr_a.push_back({8'(i), w});
      load_valid_a = 1'b1;
      load_data_a  = w;
      @(posedge clock); #1;
      if (gaps && i < 3) begin
        load_valid_a = 1'b0;
        load_data_a  = 8'hEE;
        @(posedge clock); #1;
      end
    end
    load_valid_a = 1'b0;
  endtask

  // Called in START; ack is raised in RUN cycle n.
  task automatic run_a(input int n);
    @(posedge clock);
    repeat (n - 1) @(posedge clock);
    #1 ack_a = 1'b1;
    @(posedge clock); #1 ack_a = 1'b0;
  endtask

  task automatic wait_done_a(input bit poke_go, input int exp_cnt, input int exp_to);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (done_a) seen = 1'b1;
    end
    chk("a_done_seen", int'(seen), 1);
    if (poke_go) go_a = 1'b1;
    @(posedge clock); #1 go_a = 1'b0;
    @(negedge clock);
    chk("a_idle_after_done", int'(busy_a), 0);
    chk("a_idle_cycle_count_hold", int'(cycle_count_a), exp_cnt);
    chk("a_idle_timed_out_hold", int'(timed_out_a), exp_to);
    chk("a_req_pulses_per_run", req_cnt_a - req_base_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    go_a = 0; go_z = 0; go_w = 0;
    load_valid_a = 0; load_valid_z = 0; load_valid_w = 0;
    load_data_a = 0; load_data_z = 0; load_data_w = 0;
    res_ready_a = 1; res_ready_z = 1; res_ready_w = 1;
    ack_a = 0; ack_z = 0; ack_w = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_a_ctrl", int'({busy_a, done_a, timed_out_a, load_ready_a, res_valid_a,
                            host_mem_sel_a, mem_we_a, req_a}), 0);
    chk("rst_a_cycle_count", int'(cycle_count_a), 0);
    chk("rst_a_mem_addr", int'(mem_addr_a), 0);
    chk("rst_z_ctrl", int'({busy_z, done_z, timed_out_z, req_z}), 0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Normal run: consecutive writes, ack in RUN cycle 10, go poked in DONE.
    exp_res_a.push_back(8'hA5); exp_res_a.push_back(8'h5A);
    exp_done_a.push_back({1'b0, 16'd10});
    go_pulse_a();
    chk("a_load_ready", int'(load_ready_a), 1);
    chk("a_host_sel_load", int'(host_mem_sel_a), 1);
    load_a(32'h11223344, 1'b0);
    run_a(10);
    wait_done_a(1'b1, 10, 0);

    // Backpressure: gapped load_valid, res_ready low for 3 UNLOAD cycles.
    exp_res_a.push_back(8'hA5); exp_res_a.push_back(8'h5A);
    exp_done_a.push_back({1'b0, 16'd1});
    res_ready_a = 1'b0;
    go_pulse_a();
    load_a(32'hAABBCCDD, 1'b1);
    run_a(1);
    repeat (3) begin
      @(negedge clock);
      chk("a_stall_res_valid", int'(res_valid_a), 1);
      chk("a_stall_res_data", int'(res_data_a), 8'hA5);
      chk("a_stall_mem_addr", int'(mem_addr_a), 64);
      @(posedge clock);
    end
    #1 res_ready_a = 1'b1;
    wait_done_a(1'b0, 1, 0);

    // Reset after two LOAD writes, then a full run restarting at address 0.
    go_pulse_a();
    exp_wr_a.push_back({8'd0, 8'h01}); exp_wr_a.push_back({8'd1, 8'h02});
    load_valid_a = 1'b1; load_data_a = 8'h01;
    @(posedge clock); #1 load_data_a = 8'h02;
    @(posedge clock); #1 reset_n = 1'b0; load_valid_a = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("a_rst_mid_ctrl", int'({busy_a, load_ready_a, host_mem_sel_a, mem_we_a, req_a}), 0);
    chk("a_rst_mid_cycle_count", int'(cycle_count_a), 0);
    exp_res_a.push_back(8'hA5); exp_res_a.push_back(8'h5A);
    exp_done_a.push_back({1'b0, 16'd3});
    go_pulse_a();
    load_a(32'h77889966, 1'b0);
    run_a(3);
    wait_done_a(1'b0, 3, 0);

`ifdef RUN_TIMEOUT_EN
    // No ack: timeout after 8 RUN cycles, no UNLOAD.
    exp_done_a.push_back({1'b1, 16'd8});
    go_pulse_a();
    load_a(32'h01020304, 1'b0);
    wait_done_a(1'b0, 8, 1);
    // Accepted go clears timed_out; ack on the limit cycle wins.
    go_pulse_a();
    @(negedge clock);
    chk("a_go_clears_timed_out", int'(timed_out_a), 0);
    chk("a_go_clears_cycle_count", int'(cycle_count_a), 0);
    exp_res_a.push_back(8'hA5); exp_res_a.push_back(8'h5A);
    exp_done_a.push_back({1'b0, 16'd8});
    load_a(32'h05060708, 1'b0);
    run_a(8);
    wait_done_a(1'b0, 8, 0);
`else
    // No timeout build: RUN keeps waiting well past TIMEOUT_CYCLES.
    exp_res_a.push_back(8'hA5); exp_res_a.push_back(8'h5A);
    exp_done_a.push_back({1'b0, 16'd21});
    go_pulse_a();
    load_a(32'h01020304, 1'b0);
    @(posedge clock);
    repeat (20) @(posedge clock);
    #1;
    chk("a_no_timeout_busy", int'(busy_a), 1);
    chk("a_no_timeout_flag", int'(timed_out_a), 0);
    chk("a_no_timeout_count", int'(cycle_count_a), 20);
    ack_a = 1'b1;
    @(posedge clock); #1 ack_a = 1'b0;
    wait_done_a(1'b0, 21, 0);
`endif

    // Zero-count instance: IDLE -> START -> RUN -> DONE.
    go_z = 1'b1;
    @(posedge clock); #1 go_z = 1'b0;
    @(negedge clock);
    chk("z_start_req", int'(req_z), 1);
    chk("z_start_no_load", int'(load_ready_z), 0);
    chk("z_start_host_sel", int'(host_mem_sel_z), 0);
    @(posedge clock); #1 ack_z = 1'b1;
    @(posedge clock); #1 ack_z = 1'b0;
    @(negedge clock);
    chk("z_done", int'(done_z), 1);
    chk("z_cycle_count", int'(cycle_count_z), 1);
    chk("z_timed_out", int'(timed_out_z), 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("z_idle", int'({busy_z, done_z}), 0);
    chk("z_req_pulses", req_cnt_z, 1);

    // Wrap instance: writes 254,255,0,1; ack during START ignored.
    exp_wr_w.push_back({8'd254, 8'hD1}); exp_wr_w.push_back({8'd255, 8'hD2});
    exp_wr_w.push_back({8'd0, 8'hD3});   exp_wr_w.push_back({8'd1, 8'hD4});
    exp_res_w.push_back(8'hD2);
    exp_done_w.push_back({1'b0, 16'd3});
    go_w = 1'b1;
    @(posedge clock); #1 go_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w_load_ready", int'(load_ready_w), 1);
      load_valid_w = 1'b1;
      load_data_w  = 8'hD1 + 8'(i);
      @(posedge clock); #1;
    end
    load_valid_w = 1'b0;
    ack_w = 1'b1;
    @(posedge clock); #1 ack_w = 1'b0;
    @(negedge clock);
    chk("w_start_ack_ignored", int'(res_valid_w), 0);
    chk("w_run_busy", int'(busy_w), 1);
    chk("w_run_host_sel", int'(host_mem_sel_w), 0);
    repeat (2) @(posedge clock);
    #1 ack_w = 1'b1;
    @(posedge clock); #1 ack_w = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clock);
        if (done_w) seen = 1'b1;
      end
      chk("w_done_seen", int'(seen), 1);
    end
    @(posedge clock); #1;
    chk("w_req_pulses", req_cnt_w, 1);

    repeat (2) @(posedge clock);
    chk("a_wr_queue_empty", exp_wr_a.size(), 0);
    chk("a_res_queue_empty", exp_res_a.size(), 0);
    chk("a_done_queue_empty", exp_done_a.size(), 0);
    chk("w_wr_queue_empty", exp_wr_w.size(), 0);
    chk("w_res_queue_empty", exp_res_w.size(), 0);
    chk("w_done_queue_empty", exp_done_w.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Host-side sequencer directly upstream of the processor top level. It owns the processor's req/ack start handshake and the host side of the data-memory bus. Per run it streams LOAD_WORDS operands into data memory, pulses req, waits for ack while counting cycles, then streams RESULT_WORDS results back out. It turns the single-program processor into a repeatable batch engine for benches and wrappers.

Parameters:
ADDR_W, 8, data-memory address width; addresses wrap mod 2^ADDR_W
DATA_W, 8, data-memory word width
LOAD_WORDS, 4, operand words written per run (0 legal)
LOAD_BASE, 0, first data-memory address written in LOAD
RESULT_WORDS, 2, result words read per run (0 legal)
RESULT_BASE, 64, first data-memory address read in UNLOAD
TIMEOUT_CYCLES, 1024, RUN-phase cycle limit (used only with RUN_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
go  in  1  start a run; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
timed_out  out  1  sticky; last run hit timeout; cleared by accepted go
cycle_count  out  16  RUN-phase cycles of last run, saturating at 0xFFFF
load_valid  in  1  operand stream valid
load_ready  out  1  operand stream ready
load_data  in  DATA_W  operand word
res_valid  out  1  result stream valid
res_ready  in  1  result stream ready
res_data  out  DATA_W  result word
host_mem_sel  out  1  1 = sequencer owns data-memory bus (LOAD, UNLOAD)
mem_we  out  1  data-memory write enable
mem_addr  out  ADDR_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
mem_rdata  in  DATA_W  data-memory read data, combinational from mem_addr
req  out  1  processor start pulse
ack  in  1  processor finished (level)

Behaviour:
- Reset (reset_n=0 at rising edge): state IDLE; all outputs 0; cycle_count=0; timed_out=0; indices=0. Reset mid-run abandons partial loads and unloads; req is low from the next edge.
- States: IDLE, LOAD, START, RUN, UNLOAD, DONE.
- IDLE: go=1 -> LOAD (or START if LOAD_WORDS=0). Clear timed_out, cycle_count, load and result indices. go outside IDLE is ignored.
- LOAD: load_ready=1, host_mem_sel=1. On load_valid&&load_ready, in the same cycle, mem_we=1, mem_addr=LOAD_BASE+idx, mem_wdata=load_data. idx increments. The LOAD_WORDS-th transfer -> START. load_valid=0 stalls with no write.
- START: exactly one cycle, req=1, host_mem_sel=0 -> RUN. ack is ignored in START.
- RUN: req=0, host_mem_sel=0, mem_we=0. cycle_count increments each cycle, saturating at 0xFFFF. ack=1 sampled -> UNLOAD (or DONE if RESULT_WORDS=0). The cycle in which ack is seen is counted.
- UNLOAD: host_mem_sel=1, mem_addr=RESULT_BASE+ridx, res_valid=1, res_data=mem_rdata (combinational). On res_ready, ridx increments. The RESULT_WORDS-th handshake -> DONE. res_data stays stable while res_valid&&!res_ready.
- DONE: done=1 for one cycle -> IDLE. go in the DONE cycle is ignored.
- load_ready and res_valid are 0 outside their states. mem_we is 1 only in LOAD on a transfer.
- Address arithmetic is ADDR_W-bit modular; LOAD_BASE+idx past 2^ADDR_W-1 wraps to 0.
- cycle_count and timed_out hold their values through IDLE until the next accepted go.

Optional Feature:
RUN_TIMEOUT_EN
- Defined: in RUN, if cycle_count reaches TIMEOUT_CYCLES without ack, set timed_out=1 and go directly to DONE, skipping UNLOAD (no res_valid). If ack arrives in the same cycle as the limit, ack wins: no timeout, normal UNLOAD.
- Undefined: RUN waits for ack indefinitely; timed_out stays 0.

Test Plan:
- Normal run: go; stream 0x11,0x22,0x33,0x44 with load_valid held -> writes at addrs 0..3 on 4 consecutive cycles. Then one-cycle req. ack after 10 RUN cycles -> cycle_count=10; res_data = mem[64], mem[65]; done pulses once.
- Backpressure: load_valid toggling 1,0,1,0 -> writes only on valid cycles. res_ready low 3 cycles -> res_data stable, ridx unchanged.
- Zero counts: LOAD_WORDS=0, RESULT_WORDS=0 -> IDLE->START->RUN->DONE; no mem_we, no res_valid.
- Timeout (RUN_TIMEOUT_EN, TIMEOUT_CYCLES=8): ack never asserted -> timed_out=1 and done after 8 RUN cycles; next go clears timed_out.
- Reset mid-LOAD after 2 writes -> IDLE next edge, outputs 0. A new go restarts writing at address LOAD_BASE.
- Wrap: LOAD_BASE=254, LOAD_WORDS=4 -> writes to 254, 255, 0, 1. ack asserted during START -> ignored, and req still pulses once.
